keypoint_topk_buffer: RTL and testbench
=======================================

// Module: keypoint_topk_buffer
// PURPOSE
//   Per-frame keypoint store for the feature front end: accepts scored keypoints
//   (x, y, score, descriptor) during a frame and retains only the DEPTH best by score.
//   Entries are kept sorted, highest score first, via a single-cycle insertion shift.
//   At frame end the block streams the survivors out best-first over valid/ready
//   to the matcher.
// PARAMETERS
//   DEPTH    32   number of entries retained per frame (>=2)
//   X_W      10   x-coordinate width
//   Y_W      10   y-coordinate width
//   SCORE_W  8    score width; unsigned compare
//   DESC_W   256  descriptor width
//   CNT_W    $clog2(DEPTH+1)  width of o_count (derived)
// PORTS
//   i_clk          in   1        clock
//   i_rst_n        in   1        async active-low reset
//   i_frame_start  in   1        pulse: clear buffer, enter FILL
//   i_frame_end    in   1        pulse: close frame, enter DRAIN
//   i_valid        in   1        keypoint present on i_coor_x/i_coor_y/i_score/i_descriptor
//   i_coor_x       in   X_W      keypoint x
//   i_coor_y       in   Y_W      keypoint y
//   i_score        in   SCORE_W  keypoint score
//   i_descriptor   in   DESC_W   keypoint descriptor
//   o_in_ready     out  1        1 only in FILL; inputs ignored otherwise
//   o_valid        out  1        output entry valid (DRAIN, count!=0)
//   i_ready        in   1        downstream accepts output entry
//   o_coor_x/o_coor_y/o_score/o_descriptor  out  X_W/Y_W/SCORE_W/DESC_W  head entry (index 0)
//   o_count        out  CNT_W    entries currently held
//   o_drop_cnt     out  16       keypoints lost this frame (evicted or rejected), saturating
//   o_done         out  1        one-cycle pulse when a frame's drain completes
// BEHAVIOUR
//   Reset (async): state IDLE, count 0, all entries 0, every output 0.
//   FSM: IDLE -i_frame_start-> FILL; FILL -i_frame_end-> DRAIN (or IDLE if count 0 after
//     that cycle's insert, with o_done pulse); DRAIN -last handshake-> IDLE + o_done.
//   i_frame_start wins over i_frame_end in any state; in any state it clears count,
//     entries and o_drop_cnt next cycle and goes to FILL; a drain in progress is
//     aborted without o_done.
//   Insert (FILL, i_valid): p = number of held entries with score >= i_score (ties keep
//     older first). If p < DEPTH: write at p, shift p..DEPTH-2 down by one; if
//     count==DEPTH the last entry is evicted and o_drop_cnt++; else count++.
//     If p == DEPTH (full, new score <= all): discard, o_drop_cnt++.
//   An insert in the i_frame_end cycle is still accepted. Result visible next cycle.
//   Drain: o_valid = (state==DRAIN && count!=0), registered-state derived; head data is
//     entry 0. On o_valid && i_ready: shift all entries up by one, entry DEPTH-1 <= 0,
//     count--. While i_ready=0 head data and o_valid stay stable. One entry per cycle max.
//   o_drop_cnt saturates at 16'hFFFF. o_done is high for exactly one cycle.
// TESTING
//   start; insert scores 5,9,7 at (1,1),(2,2),(3,3); end; i_ready=1 -> out 9@(2,2),
//     7@(3,3), 5@(1,1) on consecutive cycles, o_done the cycle after the last.
//   DEPTH=4: insert 10,20,30,40 then 25 -> 10 evicted, drop 1; insert 5 -> drop 2;
//     drain 40,30,25,20.
//   ties: score 8 at (1,1) then (2,2) -> (1,1) drained first.
//   drain with i_ready low 3 cycles -> o_valid=1, head data unchanged, count unchanged.
//   i_frame_start mid-drain -> next cycle FILL, count 0, o_valid 0, no o_done;
//     end with no inserts -> IDLE + o_done pulse, o_valid never 1.
//   i_rst_n low mid-fill -> all outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/keypoint_topk_buffer.sv
// Per-frame top-DEPTH keypoint store, kept sorted best-first by score.
// Drains survivors best-first over valid/ready at frame end.
module keypoint_topk_buffer #(
  parameter int DEPTH   = 32,
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int SCORE_W = 8,
  parameter int DESC_W  = 256,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_start,
  input  logic               i_frame_end,
  input  logic               i_valid,
  input  logic [X_W-1:0]     i_coor_x,
  input  logic [Y_W-1:0]     i_coor_y,
  input  logic [SCORE_W-1:0] i_score,
  input  logic [DESC_W-1:0]  i_descriptor,
  output logic               o_in_ready,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [X_W-1:0]     o_coor_x,
  output logic [Y_W-1:0]     o_coor_y,
  output logic [SCORE_W-1:0] o_score,
  output logic [DESC_W-1:0]  o_descriptor,
  output logic [CNT_W-1:0]   o_count,
  output logic [15:0]        o_drop_cnt,
  output logic               o_done
);

  localparam int EW = X_W + Y_W + SCORE_W + DESC_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  state_t           state_q;
  logic [EW-1:0]    ent_q [DEPTH];
  logic [EW-1:0]    ins_d [DEPTH];
  logic [EW-1:0]    pop_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] pos;
  logic [15:0]      drop_q;
  logic [15:0]      drop_d;
  logic             done_q;
  logic [EW-1:0]    new_ent;
  logic             full;
  logic             hs;

  function automatic logic [SCORE_W-1:0] score_of(
    input logic [EW-1:0] e
  );
    return e[DESC_W +: SCORE_W];
  endfunction

  assign new_ent = {i_coor_x, i_coor_y, i_score, i_descriptor};
  assign full    = (count_q == CNT_W'(DEPTH));
  assign hs      = (state_q == DRAIN) && (count_q != '0) && i_ready;
  assign drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

  // Insert position: held entries scoring >= new one stay ahead (older wins ties)
  always_comb begin
    pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q && score_of(ent_q[i]) >= i_score)
        pos = pos + CNT_W'(1);
    end
  end

  always_comb begin
    ins_d[0] = (pos == '0) ? new_ent : ent_q[0];
    for (int k = 1; k < DEPTH; k++) begin
      if (CNT_W'(k) == pos)
        ins_d[k] = new_ent;
      else if (CNT_W'(k) > pos)
        ins_d[k] = ent_q[k-1];
      else
        ins_d[k] = ent_q[k];
    end
    for (int k = 0; k < DEPTH - 1; k++)
      pop_d[k] = ent_q[k+1];
    pop_d[DEPTH-1] = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      drop_q  <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < DEPTH; k++)
        ent_q[k] <= '0;
    end else begin
      done_q <= 1'b0;
      if (i_frame_start) begin
        state_q <= FILL;
        count_q <= '0;
        drop_q  <= '0;
        for (int k = 0; k < DEPTH; k++)
          ent_q[k] <= '0;
      end else begin
        unique case (state_q)
          FILL: begin
            if (i_valid) begin
              if (pos != CNT_W'(DEPTH))
                ent_q <= ins_d;
              if (full)
                drop_q <= drop_d;
              else
                count_q <= count_q + CNT_W'(1);
            end
            if (i_frame_end) begin
              if (count_q == '0 && !i_valid) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end else begin
                state_q <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (hs) begin
              ent_q   <= pop_d;
              count_q <= count_q - CNT_W'(1);
              if (count_q == CNT_W'(1)) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_in_ready = (state_q == FILL);
  assign o_valid    = (state_q == DRAIN) && (count_q != '0);
  assign {o_coor_x, o_coor_y, o_score, o_descriptor} = ent_q[0];
  assign o_count    = count_q;
  assign o_drop_cnt = drop_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_keypoint_topk_buffer.sv
// Bench for keypoint_topk_buffer: sorted-queue reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_keypoint_topk_buffer;

  localparam int D  = 4;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int SW = 8;
  localparam int DW = 256;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fs, fe, iv, rdy;
  logic [XW-1:0] ix;
  logic [YW-1:0] iy;
  logic [SW-1:0] is;
  logic [DW-1:0] id;
  logic          in_ready, ov, done;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;
  logic [SW-1:0] os;
  logic [DW-1:0] od;
  logic [CW-1:0] cnt;
  logic [15:0]   drop;

  keypoint_topk_buffer #(
    .DEPTH(D), .X_W(XW), .Y_W(YW), .SCORE_W(SW), .DESC_W(DW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_frame_start(fs), .i_frame_end(fe),
    .i_valid(iv), .i_coor_x(ix), .i_coor_y(iy),
    .i_score(is), .i_descriptor(id),
    .o_in_ready(in_ready), .o_valid(ov), .i_ready(rdy),
    .o_coor_x(ox), .o_coor_y(oy), .o_score(os),
    .o_descriptor(od), .o_count(cnt),
    .o_drop_cnt(drop), .o_done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
  } kp_t;

  kp_t mq[$];
  int  mst;
  int  mdrop;
  bit  mdone;
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string n, input logic [DW-1:0] a,
                     input logic [DW-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mst   = 0;
    mdrop = 0;
    mdone = 0;
  endtask

  task automatic check_all();
    kp_t h;
    h = '{x: '0, y: '0, s: '0, d: '0};
    if (mq.size() > 0) h = mq[0];
    chk("in_ready", in_ready, mst == 1);
    chk("o_valid", ov, mst == 2 && mq.size() > 0);
    chk("o_coor_x", ox, h.x);
    chk("o_coor_y", oy, h.y);
    chk("o_score", os, h.s);
    chk("o_desc", od, h.d);
    chk("o_count", cnt, mq.size());
    chk("o_drop_cnt", drop, mdrop);
    chk("o_done", done, mdone);
  endtask

  task automatic step(input bit f_s, input bit f_e, input bit v,
                      input int x, input int y, input int s,
                      input bit r);
    kp_t k;
    int  p;
    bit  pre_valid;
    k.x = XW'(x);
    k.y = YW'(y);
    k.s = SW'(s);
    k.d = {8{$urandom}};
    fs = f_s; fe = f_e; iv = v; rdy = r;
    ix = k.x; iy = k.y; is = k.s; id = k.d;
    pre_valid = (mst == 2) && (mq.size() > 0);
    mdone = 0;
    if (f_s) begin
      mst = 1;
      mq.delete();
      mdrop = 0;
    end else if (mst == 1) begin
      if (v) begin
        p = 0;
        foreach (mq[i]) if (mq[i].s >= k.s) p++;
        if (p < D) begin
          mq.insert(p, k);
          if (mq.size() > D) begin
            void'(mq.pop_back());
            if (mdrop < 65535) mdrop++;
          end
        end else if (mdrop < 65535) begin
          mdrop++;
        end
      end
      if (f_e) begin
        if (mq.size() == 0) begin
          mst = 0;
          mdone = 1;
        end else begin
          mst = 2;
        end
      end
    end else if (mst == 2) begin
      if (pre_valid && r) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          mst = 0;
          mdone = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ins(input int x, input int y, input int s);
    step(0, 0, 1, x, y, s, 0);
  endtask

  task automatic start_f();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic end_f();
    step(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic pull(input bit r);
    step(0, 0, 0, 0, 0, 0, r);
  endtask

  initial begin
    rst_n = 1'b0;
    fs = 0; fe = 0; iv = 0; rdy = 0;
    ix = '0; iy = '0; is = '0; id = '0;
    model_reset();
    #1;
    check_all();
    chk("reset_count", cnt, 0);
    chk("reset_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic ordering
    start_f();
    ins(1, 1, 5);
    ins(2, 2, 9);
    ins(3, 3, 7);
    end_f();
    chk("t1_head0_s", os, 9);
    chk("t1_head0_x", ox, 2);
    pull(1);
    chk("t1_head1_s", os, 7);
    chk("t1_head1_x", ox, 3);
    pull(1);
    chk("t1_head2_s", os, 5);
    chk("t1_head2_y", oy, 1);
    pull(1);
    chk("t1_done", done, 1);
    chk("t1_valid_off", ov, 0);
    pull(0);
    chk("t1_done_once", done, 0);

    // eviction and rejection when full
    start_f();
    ins(0, 0, 10);
    ins(0, 1, 20);
    ins(0, 2, 30);
    ins(0, 3, 40);
    ins(0, 4, 25);
    chk("t2_drop1", drop, 1);
    ins(0, 5, 5);
    chk("t2_drop2", drop, 2);
    end_f();
    chk("t2_d0", os, 40);
    pull(1);
    chk("t2_d1", os, 30);
    pull(1);
    chk("t2_d2", os, 25);
    pull(1);
    chk("t2_d3", os, 20);
    pull(1);
    chk("t2_done", done, 1);

    // ties keep arrival order
    start_f();
    ins(1, 1, 8);
    ins(2, 2, 8);
    end_f();
    chk("t3_tie_x", ox, 1);
    pull(1);
    chk("t3_tie_x2", ox, 2);
    pull(1);

    // back-pressure holds head
    start_f();
    ins(4, 4, 3);
    ins(6, 6, 12);
    end_f();
    repeat (3) pull(0);
    chk("t4_hold_valid", ov, 1);
    chk("t4_hold_x", ox, 6);
    chk("t4_hold_cnt", cnt, 2);
    pull(1);
    pull(1);

    // frame start aborts a drain
    start_f();
    ins(1, 2, 50);
    ins(3, 4, 60);
    ins(5, 6, 70);
    end_f();
    pull(1);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("t5_valid", ov, 0);
    chk("t5_cnt", cnt, 0);
    chk("t5_fill", in_ready, 1);
    chk("t5_nodone", done, 0);
    end_f();
    chk("t5_done", done, 1);
    chk("t5_idle", in_ready, 0);

    // insert in frame-end cycle of an empty frame
    start_f();
    step(0, 1, 1, 9, 9, 33, 0);
    chk("t6_cnt", cnt, 1);
    chk("t6_valid", ov, 1);
    pull(1);

    // async reset mid-fill
    start_f();
    ins(7, 7, 99);
    ins(8, 8, 98);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t7_cnt", cnt, 0);
    chk("t7_score", os, 0);
    chk("t7_ready", in_ready, 0);
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    pull(1);
    chk("t7_idle", in_ready, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 1023),
           $urandom_range(0, 1023),
           $urandom_range(0, 15),
           $urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
